// File: rtl/multicycle_ctrl_pkg.sv
// Shared core types package: ALU/immediate encodings plus the multi-cycle controller state and next-PC select.
// Revision: 1.0
`default_nettype none
package types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencing controller: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, HALT and instret.
// Revision: 1.0
`default_nettype none
module multicycle_ctrl
  import types::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_regWrite,
  input  logic                 i_memRead,
  input  logic                 i_memWrite,
  input  logic                 i_branch,
  input  logic                 i_jump,
  input  logic                 i_jalr,
  input  logic                 i_illegal,
  input  logic                 i_branchTaken,
  input  logic                 i_imem_ready,
  input  logic                 i_dmem_ready,
  output logic                 o_imem_req,
  output logic                 o_irWrite,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic                 o_regfile_we,
  output logic                 o_pcWrite,
  output pc_sel_e              o_pcSel,
  output logic                 o_retire,
  output logic                 o_halted,
  output ctrl_state_e          o_state,
  output logic [INSTRET_W-1:0] o_instret
);

  ctrl_state_e state_q, state_d;
  logic        taken_q;
  logic        taken;
  logic        retire;

  assign o_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FETCH;
      taken_q   <= 1'b0;
      o_instret <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) taken_q <= i_branch & i_branchTaken;
      if (retire) o_instret <= o_instret + INSTRET_W'(1);
    end
  end

  // Branch decision is live in EXEC; MEM-stage retires rely on the captured copy.
  assign taken = (state_q == EXEC) ? (i_branch & i_branchTaken) : taken_q;

  always_comb begin
    state_d      = state_q;
    o_imem_req   = 1'b0;
    o_irWrite    = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_regfile_we = 1'b0;
    o_halted     = 1'b0;
    retire       = 1'b0;
    case (state_q)
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_irWrite = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: state_d = i_illegal ? HALT : EXEC;
      EXEC: begin
        if (i_memRead | i_memWrite) begin
          state_d = MEM;
        end else if (i_regWrite) begin
          state_d = WB;
        end else begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_memWrite;
        if (i_dmem_ready) begin
          if (i_memRead) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        o_regfile_we = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      HALT: begin
        o_halted = 1'b1;
        state_d  = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    o_pcWrite = retire;
    o_retire  = retire;
    o_pcSel   = PC_PLUS4;
    if (retire) begin
      if (i_jalr)      o_pcSel = PC_JALR;
      else if (i_jump) o_pcSel = PC_JAL;
      else if (taken)  o_pcSel = PC_BRANCH;
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32 core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB using the `decoder` control outputs. It drives the enables for the instruction and data memory ports, the IR, the PC and the register file. It also handles variable-latency memory handshakes, halts on illegal instructions and counts retired instructions.

## Interface
Parameters:
- `INSTRET_W`, 32: width of the retired-instruction counter.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_regWrite`, `i_memRead`, `i_memWrite`, `i_branch`, `i_jump`, `i_jalr`  in  1 each  decoder outputs for the instruction currently in the IR.
- `i_illegal`  in  1  the decoder flags the IR opcode as unsupported.
- `i_branchTaken`  in  1  ALU compare result; valid in EXEC.
- `i_imem_ready`  in  1  instruction memory has data or is accepting the request this cycle.
- `i_dmem_ready`  in  1  data memory has completed the access this cycle.
- `o_imem_req`  out  1  instruction fetch request.
- `o_irWrite`  out  1  load the IR from instruction memory read data.
- `o_dmem_req`  out  1  data memory request.
- `o_dmem_we`  out  1  data memory write enable; valid only while `o_dmem_req` is high.
- `o_regfile_we`  out  1  register file write strobe.
- `o_pcWrite`  out  1  update the PC this cycle.
- `o_pcSel`  out  `pc_sel_e`  next-PC source: `PC_PLUS4`, `PC_BRANCH`, `PC_JAL`, `PC_JALR`.
- `o_retire`  out  1  one-cycle pulse when an instruction completes.
- `o_halted`  out  1  controller is in HALT.
- `o_state`  out  `ctrl_state_e`  current state, for debug and the bench.
- `o_instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is FETCH.
- FETCH: `o_imem_req`=1 and stays high until `i_imem_ready`. In the ready cycle, `o_irWrite`=1 and the next state is DECODE.
- DECODE: lasts 1 cycle; the IR is stable and the decoder outputs are sampled. If `i_illegal`, go to HALT; otherwise go to EXEC.
- EXEC: lasts 1 cycle. `taken_q` is registered from `i_branch & i_branchTaken`. Transitions:
  - `i_memRead|i_memWrite` → MEM.
  - `i_regWrite` → WB. This covers ALU ops, LUI/AUIPC, JAL and JALR.
  - Otherwise (branch) → FETCH. This is the retire cycle.
- MEM: `o_dmem_req`=1 and `o_dmem_we`=`i_memWrite`, both held until `i_dmem_ready`. In the ready cycle, go to WB if `i_memRead`; otherwise go to FETCH, and this is the retire cycle.
- WB: lasts 1 cycle, `o_regfile_we`=1, and this is the retire cycle; next state is FETCH.
- Retire cycle: `o_pcWrite`=1 and `o_retire`=1, and `o_instret` increments on that edge.
- `o_pcSel` in the retire cycle, highest priority first:
  - `i_jalr` → `PC_JALR`.
  - `i_jump` → `PC_JAL`.
  - branch taken (from EXEC, the live `i_branch & i_branchTaken`; elsewhere, `taken_q`) → `PC_BRANCH`.
  - otherwise `PC_PLUS4`.
- `o_pcSel` is `PC_PLUS4` in all other cycles.
- HALT: absorbing. All strobes and requests are 0 and `o_halted`=1. Only reset leaves HALT.
- `o_instret` wraps modulo 2^`INSTRET_W` with no saturation.
- Decoder inputs are assumed stable from DECODE until retire, because the IR is written only in FETCH.

## Timing
- Reset values of the outputs:
  - `o_state`=FETCH.
  - `o_imem_req`=1 combinationally from the state.
  - All other strobes = 0.
  - `o_pcSel`=`PC_PLUS4`.
  - `o_halted`=0 and `o_instret`=0.
- All outputs are Moore-decoded from the state, except `o_irWrite` (gated by `i_imem_ready`) and the retire strobes in MEM (gated by `i_dmem_ready`).
- Cycles with zero-wait memory: ALU/JAL/JALR 4 (F,D,E,W); load 5; store 4 (F,D,E,M); branch 3 (F,D,E). Each wait cycle adds 1.
- A request is never withdrawn before ready. A ready without a request is ignored.
- Asserting reset at any point, including mid-MEM, returns to FETCH immediately. It drops `o_dmem_req` asynchronously and clears `o_instret`.

## Structure
- Add `ctrl_state_e` and `pc_sel_e` to the shared `types` package, next to `alu_op_e` and `imm_type_e`.
- Single module with no sub-modules. The state register, next-state logic, output decode, `taken_q` and the instret counter all sit in one file.

## Test plan
- ADDI `32'h00500093` (decoder-driven), zero-wait memory:
  - States go FETCH→DECODE→EXEC→WB.
  - In cycle 4: `o_regfile_we`=1, `o_pcWrite`=1 and `o_pcSel`=`PC_PLUS4`.
  - `o_instret` reads 1.
- SW `32'h0021A423` with `i_dmem_ready` delayed 3 cycles:
  - `o_dmem_req`=1 and `o_dmem_we`=1 for 4 cycles.
  - Retire happens in the MEM ready cycle.
  - `o_regfile_we` is never asserted.
- BEQ `32'h00208663`:
  - With `i_branchTaken`=1, retire in EXEC, 3 cycles total, `o_pcSel`=`PC_BRANCH`.
  - Repeat with 0: `o_pcSel`=`PC_PLUS4`.
- JAL `32'h020000EF`, then LUI `32'h123450B7`, back to back:
  - JAL: WB with `o_pcSel`=`PC_JAL`.
  - LUI: WB with `PC_PLUS4`.
  - `o_instret` advances by 2 over 8 cycles.
- `i_illegal`=1 in DECODE:
  - Enters HALT with `o_halted`=1, and `o_imem_req` stays 0 for 20 cycles.
  - A reset then returns the controller to FETCH.
- Load with `i_rst_n` dropped during MEM wait:
  - `o_dmem_req` falls with no clock edge, and the state reads FETCH.
  - `o_instret`=0, and `o_regfile_we` is never asserted.
